alu5_batch_accum: RTL and testbench

//  Registered stage downstream of the 5-bit integrated adder/subtractor/abs/less-than block.

---
 rtl/alu5_pkg.sv | 20 ++
 rtl/sat_accum_add.sv | 23 ++
 rtl/alu5_batch_accum.sv | 124 ++++++++++++
 tb/tb_alu5_batch_accum.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu5_pkg.sv
// Shared types and default widths for the ALU result batch accumulator.
package alu5_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ABS = 2'b10,
        OP_CMP = 2'b11
    } op_t;

    typedef enum logic {
        S_ACCUM = 1'b0,
        S_DONE  = 1'b1
    } state_t;

    localparam int unsigned DEF_WIDTH     = 5;
    localparam int unsigned DEF_ACC_WIDTH = 8;
    localparam int unsigned DEF_BATCH     = 4;

endpackage

// File: rtl/sat_accum_add.sv
// Signed saturating adder: clamps acc + operand to the W-bit signed range.
module sat_accum_add #(
    parameter int unsigned W = 8
) (
    input  logic signed [W-1:0] acc_i,
    input  logic signed [W-1:0] operand_i,
    output logic signed [W-1:0] result_c_o,
    output logic                clamp_c_o
);

    logic signed [W:0] full;

    // One guard bit; a disagreement between the top two bits means overflow.
    always_comb begin
        full       = (W+1)'(acc_i) + (W+1)'(operand_i);
        clamp_c_o  = full[W] ^ full[W-1];
        result_c_o = full[W-1:0];
        if (clamp_c_o) begin
            result_c_o = full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/alu5_batch_accum.sv
// Batches ALU result beats into a saturated running total with sticky flags,
// then holds the summary on a valid/ready output until it is taken.
module alu5_batch_accum
    import alu5_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int unsigned BATCH     = DEF_BATCH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    op,
    input  logic [WIDTH-1:0]              sum,
    input  logic [WIDTH-1:0]              diff,
    input  logic [WIDTH-1:0]              abs_sum,
    input  logic                          of_add,
    input  logic                          of_sub,
    input  logic                          lessthan,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_WIDTH-1:0]          acc_out,
    output logic [$clog2(BATCH+1)-1:0]    lt_count,
    output logic                          ovf_flag,
    output logic                          sat_flag
);

    localparam int unsigned CNT_W = $clog2(BATCH + 1);

    state_t                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [CNT_W-1:0]            lt_q, lt_d;
    logic                        ovf_q, ovf_d;
    logic                        sat_q, sat_d;

    logic signed [ACC_WIDTH-1:0] operand;
    logic signed [ACC_WIDTH-1:0] add_res;
    logic                        add_clamp;
    op_t                         op_e;

    assign op_e = op_t'(op);

    // ABS is an unsigned magnitude, so it is zero-extended; CMP contributes nothing.
    always_comb begin
        operand = '0;
        case (op_e)
            OP_ADD: operand = ACC_WIDTH'($signed(sum));
            OP_SUB: operand = ACC_WIDTH'($signed(diff));
            OP_ABS: operand = ACC_WIDTH'(abs_sum);
            OP_CMP: operand = '0;
        endcase
    end

    sat_accum_add #(.W(ACC_WIDTH)) u_sat_add (
        .acc_i      (acc_q),
        .operand_i  (operand),
        .result_c_o (add_res),
        .clamp_c_o  (add_clamp)
    );

    assign in_ready = (state_q == S_ACCUM) && !reset;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        lt_d    = lt_q;
        ovf_d   = ovf_q;
        sat_d   = sat_q;
        case (state_q)
            S_ACCUM: begin
                if (in_valid && in_ready) begin
                    acc_d = add_res;
                    sat_d = sat_q | add_clamp;
                    lt_d  = lt_q + CNT_W'(lessthan);
                    ovf_d = ovf_q | ((op_e == OP_ADD) & of_add) | ((op_e == OP_SUB) & of_sub);
                    if (cnt_q == CNT_W'(BATCH - 1)) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    lt_d    = '0;
                    ovf_d   = 1'b0;
                    sat_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            lt_q    <= '0;
            ovf_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            lt_q    <= lt_d;
            ovf_q   <= ovf_d;
            sat_q   <= sat_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign acc_out   = acc_q;
    assign lt_count  = lt_q;
    assign ovf_flag  = ovf_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_alu5_batch_accum.sv
// Two instances (8-bit and 6-bit accumulators) driven in lockstep and
// compared every cycle against an integer-arithmetic reference model.
module tb_alu5_batch_accum;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       out_ready;
    logic [1:0] op;
    logic [4:0] sum, diff, abs_sum;
    logic       of_add, of_sub, lessthan;

    logic       in_ready8, out_valid8, ovf8, sat8;
    logic [7:0] acc8;
    logic [2:0] lt8;
    logic       in_ready6, out_valid6, ovf6, sat6;
    logic [5:0] acc6;
    logic [2:0] lt6;

    int checks   = 0;
    int failures = 0;

    int m_acc8, m_acc6, m_lt, m_beats;
    bit m_ovf, m_sat8, m_sat6, m_done;

    always #5 clk = ~clk;

    alu5_batch_accum u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
        .op(op), .sum(sum), .diff(diff), .abs_sum(abs_sum),
        .of_add(of_add), .of_sub(of_sub), .lessthan(lessthan),
        .out_valid(out_valid8), .out_ready(out_ready),
        .acc_out(acc8), .lt_count(lt8), .ovf_flag(ovf8), .sat_flag(sat8)
    );

    alu5_batch_accum #(.ACC_WIDTH(6)) u_dut6 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready6),
        .op(op), .sum(sum), .diff(diff), .abs_sum(abs_sum),
        .of_add(of_add), .of_sub(of_sub), .lessthan(lessthan),
        .out_valid(out_valid6), .out_ready(out_ready),
        .acc_out(acc6), .lt_count(lt6), .ovf_flag(ovf6), .sat_flag(sat6)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int v, input int w);
        int hi = (1 << (w - 1)) - 1;
        int lo = -(1 << (w - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    task automatic model_clear();
        m_acc8 = 0; m_acc6 = 0; m_lt = 0; m_beats = 0;
        m_ovf = 0; m_sat8 = 0; m_sat6 = 0; m_done = 0;
    endtask

    // Reference behaviour for one clock edge, using the inputs as driven.
    task automatic model_edge();
        int o, s;
        if (reset) begin
            model_clear();
        end else if (!m_done) begin
            if (in_valid) begin
                case (op)
                    2'd0:    o = int'($signed(sum));
                    2'd1:    o = int'($signed(diff));
                    2'd2:    o = int'(abs_sum);
                    default: o = 0;
                endcase
                s = clamp(m_acc8 + o, 8);
                if (s != m_acc8 + o) m_sat8 = 1;
                m_acc8 = s;
                s = clamp(m_acc6 + o, 6);
                if (s != m_acc6 + o) m_sat6 = 1;
                m_acc6 = s;
                m_lt += int'(lessthan);
                if ((op == 2'd0 && of_add) || (op == 2'd1 && of_sub)) m_ovf = 1;
                m_beats++;
                if (m_beats == 4) begin
                    m_done  = 1;
                    m_beats = 0;
                end
            end
        end else if (out_ready) begin
            model_clear();
        end
    endtask

    task automatic check_all();
        int exp_rdy = (!m_done && !reset) ? 1 : 0;
        chk("in_ready8", int'(in_ready8), exp_rdy);
        chk("in_ready6", int'(in_ready6), exp_rdy);
        chk("out_valid8", int'(out_valid8), int'(m_done));
        chk("out_valid6", int'(out_valid6), int'(m_done));
        chk("acc8", int'($signed(acc8)), m_acc8);
        chk("acc6", int'($signed(acc6)), m_acc6);
        chk("lt8", int'(lt8), m_lt);
        chk("lt6", int'(lt6), m_lt);
        chk("ovf8", int'(ovf8), int'(m_ovf));
        chk("ovf6", int'(ovf6), int'(m_ovf));
        chk("sat8", int'(sat8), int'(m_sat8));
        chk("sat6", int'(sat6), int'(m_sat6));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic beat(input logic [1:0] o, input logic [4:0] val, input logic lt, input logic of);
        in_valid = 1'b1;
        op       = o;
        sum      = (o == 2'd0) ? val : 5'($urandom);
        diff     = (o == 2'd1) ? val : 5'($urandom);
        abs_sum  = (o == 2'd2) ? val : 5'($urandom);
        of_add   = (o == 2'd0) ? of : 1'b0;
        of_sub   = (o == 2'd1) ? of : 1'b0;
        lessthan = lt;
        step();
        in_valid = 1'b0;
    endtask

    task automatic take_summary();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        model_clear();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'd0;
        sum = '0; diff = '0; abs_sum = '0; of_add = 0; of_sub = 0; lessthan = 0;

        // Reset held for two cycles
        step();
        step();
        chk("rst_ready_low", int'(in_ready8), 0);
        reset = 1'b0;
        #1;
        chk("rst_ready_high", int'(in_ready8), 1);
        @(negedge clk);

        // Signed ADD batch
        beat(2'd0, 5'd3, 1'b0, 1'b0);
        beat(2'd0, 5'd5, 1'b0, 1'b0);
        beat(2'd0, 5'b11110, 1'b0, 1'b0);
        chk("t2_not_done", int'(out_valid8), 0);
        beat(2'd0, 5'd7, 1'b0, 1'b0);
        chk("t2_valid", int'(out_valid8), 1);
        chk("t2_acc", int'($signed(acc8)), 13);
        take_summary();

        // SUB of -16 saturates the 6-bit accumulator only
        repeat (4) beat(2'd1, 5'b10000, 1'b0, 1'b0);
        chk("t3_acc6", int'($signed(acc6)), -32);
        chk("t3_sat6", int'(sat6), 1);
        chk("t3_acc8", int'($signed(acc8)), -64);
        chk("t3_ovf", int'(ovf6), 0);
        take_summary();

        // CMP beats count lessthan but leave the total alone
        repeat (3) beat(2'd3, 5'd9, 1'b1, 1'b1);
        beat(2'd0, 5'd4, 1'b0, 1'b1);
        chk("t4_acc", int'($signed(acc8)), 4);
        chk("t4_lt", int'(lt8), 3);
        chk("t4_ovf", int'(ovf8), 1);

        // Summary is held while the consumer stalls; input beats are refused
        in_valid = 1'b1;
        repeat (3) begin
            step();
            chk("t5_hold_acc", int'($signed(acc8)), 4);
            chk("t5_hold_ready", int'(in_ready8), 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("t5_clr_acc", int'($signed(acc8)), 0);
        chk("t5_ready", int'(in_ready8), 1);

        // Mid-batch reset discards partial beats
        beat(2'd0, 5'd6, 1'b0, 1'b0);
        beat(2'd0, 5'd6, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_rst_acc", int'($signed(acc8)), 0);
        repeat (3) beat(2'd2, 5'b10000, 1'b0, 1'b0);
        chk("t6_not_done", int'(out_valid8), 0);
        beat(2'd2, 5'b10000, 1'b0, 1'b0);
        chk("t6_valid", int'(out_valid8), 1);
        chk("t6_acc", int'($signed(acc8)), 64);
        take_summary();

        // Randomised traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 2) == 0);
            reset     = ($urandom_range(0, 49) == 0);
            op        = 2'($urandom);
            sum       = 5'($urandom);
            diff      = 5'($urandom);
            abs_sum   = 5'($urandom);
            of_add    = 1'($urandom);
            of_sub    = 1'($urandom);
            lessthan  = 1'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
